multi_delay_core: RTL and testbench
===================================

MULTI_DELAY_CORE -- requirements
Module: multi_delay_core

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent delay-line channels (1..16).
REQ-002 SHALL have parameter TAP_W, default 9: tap-count width per channel.
REQ-003 SHALL have parameter NATIVE_DATA_WIDTH, default 32: native bus data width (>= TAP_W+1).
REQ-004 SHALL have parameter VTC_WAIT, default 10: cycles held with EN_VTC low before and after a tap load.
REQ-005 SHALL have derived constant NATIVE_ADDR_WIDTH = clog2(NUM_CH)+2: upper bits select the channel, lower 2 bits select the register.
REQ-006 SHALL have ports in this order:
  - NATIVE_CLK in 1: the single clock.
  - NATIVE_RST in 1: reset, asynchronous, active-high.
  - NATIVE_EN in 1: one-cycle access request.
  - NATIVE_WR in 1: 1 = write, 0 = read.
  - NATIVE_ADDR in NATIVE_ADDR_WIDTH: {channel, reg}.
  - NATIVE_DATA_IN in NATIVE_DATA_WIDTH: write data.
  - NATIVE_DATA_OUT out NATIVE_DATA_WIDTH: read data, valid while NATIVE_READY=1.
  - NATIVE_READY out 1: one-cycle completion pulse.
  - CNTVALUEIN out NUM_CH*TAP_W: per-channel tap value to the delay primitives.
  - LOAD out NUM_CH: per-channel one-cycle load strobe.
  - EN_VTC out NUM_CH: per-channel VT-compensation enable.
  - CNTVALUEOUT in NUM_CH*TAP_W: per-channel current tap value from the primitives.

Function
REQ-007 SHALL map registers per channel as:
  - reg0 TAP: write = load the tap value; read = CNTVALUEOUT.
  - reg1 CTRL: bit0 = VTC enable while idle, reset 1.
  - reg2 STEP: write = signed TAP_W-bit delta applied to the last loaded value.
  - reg3 STATUS: read-only; bit0 busy, bit1 sticky saturation flag (write-1-to-clear through the reg3 write).
REQ-008 SHALL accept NATIVE_EN only in IDLE; NATIVE_EN asserted while busy SHALL be ignored, with no READY pulse and no state change.
REQ-009 SHALL capture WR, ADDR and DATA_IN on the accepting edge.
REQ-010 SHALL sequence the FSM as follows:
  - IDLE -> RD on a read.
  - IDLE -> VTC_OFF on a TAP or STEP write.
  - IDLE -> DONE on a CTRL or STATUS write.
  - VTC_OFF (EN_VTC[ch]=0, VTC_WAIT cycles) -> LOAD (LOAD[ch]=1, one cycle) -> SETTLE (VTC_WAIT cycles) -> VTC_ON (EN_VTC[ch] restored from CTRL bit0) -> DONE.
  - RD -> DONE.
  - DONE (READY=1, one cycle) -> IDLE.
REQ-011 SHALL give read latency of exactly 2 cycles from the accepting edge to READY.
REQ-012 SHALL give tap-write latency of exactly 2*VTC_WAIT+3 cycles from the accepting edge to READY.
REQ-013 SHALL compute the STEP target as shadow[ch] + delta, clamped to 0..2^TAP_W-1; clamping SHALL set the sticky saturation flag.
REQ-014 SHALL load TAP writes using DATA_IN[TAP_W-1:0]; upper bits SHALL be ignored.
REQ-015 SHALL update shadow[ch] to the loaded value in the LOAD cycle; CNTVALUEIN[ch] SHALL equal shadow[ch] at all times.
REQ-016 SHALL touch only the addressed channel's LOAD and EN_VTC bits; all other channels SHALL remain unaffected.
REQ-017 SHALL apply a CTRL write to EN_VTC[ch] in the DONE cycle.
REQ-018 SHALL treat an address whose channel index is >= NUM_CH as follows: a read returns 0; a write completes through DONE with no side effects.
REQ-019 SHALL drive NATIVE_DATA_OUT to 0 whenever READY=0.

Reset
REQ-020 SHALL, on NATIVE_RST asserted, immediately force:
  - FSM to IDLE;
  - READY=0, LOAD=0, EN_VTC all 1;
  - shadow and CNTVALUEIN to 0;
  - CTRL bit0=1 and saturation flags = 0;
  - NATIVE_DATA_OUT=0.
REQ-021 SHALL abort an in-flight load on reset with no READY pulse, and SHALL resume operation on the first edge after deassertion.

Structure
REQ-022 SHALL keep the FSM state enumeration, register offsets (TAP/CTRL/STEP/STATUS) and the clog2 helper in a shared package, delay_ctrl_pkg.
REQ-023 SHALL instantiate one sub-module, vtc_load_seq, containing the VTC_OFF/LOAD/SETTLE/VTC_ON counter and sequencer, shared by all channels.

Verification
REQ-024 SHALL verify a tap write: ch2 TAP=0x055 -> EN_VTC[2] low for 10 cycles, LOAD[2] pulse with CNTVALUEIN[2]=0x055, READY at cycle 23, other channels untouched.
REQ-025 SHALL verify a read: ch1 with CNTVALUEOUT[1]=0x1A3 -> READY at cycle 2 with DATA_OUT=0x1A3.
REQ-026 SHALL verify STEP saturation:
  - shadow=0x1F0, STEP +0x20 -> loaded value 0x1FF and STATUS bit1=1;
  - STEP -3 from 0 -> loaded value 0, flag set.
REQ-027 SHALL verify a busy collision: NATIVE_EN pulsed during SETTLE -> ignored, exactly one READY pulse.
REQ-028 SHALL verify reset mid-operation: NATIVE_RST during VTC_OFF -> EN_VTC all 1, LOAD=0, no READY; a following read returns correct data.
REQ-029 SHALL verify CTRL control: CTRL bit0=0 on ch0 -> EN_VTC[0]=0 after DONE; a subsequent TAP write leaves EN_VTC[0]=0 on completion.

Source files
------------

// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the multi-channel delay-line controller:
// FSM encodings, per-channel register offsets and a constant clog2 helper.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_RD   = 2'd1,
        CS_SEQ  = 2'd2,
        CS_DONE = 2'd3
    } core_state_t;

    typedef enum logic [2:0] {
        SQ_IDLE    = 3'd0,
        SQ_VTC_OFF = 3'd1,
        SQ_LOAD    = 3'd2,
        SQ_SETTLE  = 3'd3,
        SQ_VTC_ON  = 3'd4
    } seq_state_t;

    localparam logic [1:0] REG_TAP    = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STEP   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vtc_load_seq.sv
// Shared tap-load sequencer: holds VT compensation off, issues the load,
// lets the primitive settle, then hands compensation back.
module vtc_load_seq
    import delay_ctrl_pkg::*;
#(
    parameter int VTC_WAIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output seq_state_t o_state,
    output logic       o_enter_load,
    output logic       o_enter_vtc_on,
    output logic       o_done
);

    localparam int              CNT_W    = clog2(VTC_WAIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VTC_WAIT - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_last;

    assign w_cnt_last     = (r_cnt == CNT_LAST);
    assign o_state        = r_state;
    assign o_enter_load   = (r_state == SQ_VTC_OFF) && w_cnt_last;
    assign o_enter_vtc_on = (r_state == SQ_SETTLE) && w_cnt_last;
    assign o_done         = (r_state == SQ_VTC_ON);

    // Phase sequencer with a shared wait counter for both hold windows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SQ_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SQ_IDLE: begin
                    if (i_start) begin
                        r_state <= SQ_VTC_OFF;
                        r_cnt   <= '0;
                    end
                end
                SQ_VTC_OFF: begin
                    if (w_cnt_last) begin
                        r_state <= SQ_LOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SQ_LOAD: begin
                    r_state <= SQ_SETTLE;
                    r_cnt   <= '0;
                end
                SQ_SETTLE: begin
                    if (w_cnt_last) begin
                        r_state <= SQ_VTC_ON;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SQ_VTC_ON: r_state <= SQ_IDLE;
                default: begin
                    r_state <= SQ_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_delay_core.sv
// Native-bus controller for NUM_CH delay-line primitives: tap load/step,
// per-channel VTC control and saturation status.
module multi_delay_core
    import delay_ctrl_pkg::*;
#(
    parameter int  NUM_CH            = 4,
    parameter int  TAP_W             = 9,
    parameter int  NATIVE_DATA_WIDTH = 32,
    parameter int  VTC_WAIT          = 10,
    localparam int NATIVE_ADDR_WIDTH = clog2(NUM_CH) + 2
) (
    input  logic                         NATIVE_CLK,
    input  logic                         NATIVE_RST,
    input  logic                         NATIVE_EN,
    input  logic                         NATIVE_WR,
    input  logic [NATIVE_ADDR_WIDTH-1:0] NATIVE_ADDR,
    input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
    output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    output logic                         NATIVE_READY,
    output logic [NUM_CH*TAP_W-1:0]      CNTVALUEIN,
    output logic [NUM_CH-1:0]            LOAD,
    output logic [NUM_CH-1:0]            EN_VTC,
    input  logic [NUM_CH*TAP_W-1:0]      CNTVALUEOUT
);

    localparam int              CH_W    = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam logic [TAP_W-1:0] TAP_MAX = '1;

    core_state_t                     r_state;
    logic [CH_W-1:0]                 r_idx;
    logic                            r_valid;
    logic [1:0]                      r_reg;
    logic [TAP_W-1:0]                r_delta;
    logic [NUM_CH-1:0][TAP_W-1:0]    r_shadow;
    logic [NUM_CH-1:0]               r_ctrl;
    logic [NUM_CH-1:0]               r_sat;
    logic [NUM_CH-1:0]               r_load;
    logic [NUM_CH-1:0]               r_en_vtc;
    logic                            r_ready;
    logic [NATIVE_DATA_WIDTH-1:0]    r_data_out;

    logic [NUM_CH-1:0][TAP_W-1:0]    w_cvo;
    logic [4:0]                      w_ch_in;
    logic [CH_W-1:0]                 w_idx_in;
    logic                            w_valid_in;
    logic [1:0]                      w_reg_in;
    logic                            w_is_load_in;
    logic                            w_seq_start;
    seq_state_t                      w_seq_state;
    logic                            w_enter_load;
    logic                            w_enter_vtc_on;
    logic                            w_seq_done;
    logic                            w_busy;
    logic [TAP_W+1:0]                w_sum;
    logic [TAP_W-1:0]                w_target;
    logic                            w_clamp;
    logic [NATIVE_DATA_WIDTH-1:0]    w_rd_data;
    logic                            w_unused_data;

    assign w_cvo         = CNTVALUEOUT;
    assign w_ch_in       = 5'(NATIVE_ADDR >> 2);
    assign w_idx_in      = CH_W'(w_ch_in);
    assign w_valid_in    = (w_ch_in < 5'(NUM_CH));
    assign w_reg_in      = NATIVE_ADDR[1:0];
    assign w_is_load_in  = w_valid_in && ((w_reg_in == REG_TAP) || (w_reg_in == REG_STEP));
    assign w_seq_start   = (r_state == CS_IDLE) && NATIVE_EN && NATIVE_WR && w_is_load_in;
    assign w_busy        = (w_seq_state != SQ_IDLE);
    assign w_unused_data = ^NATIVE_DATA_IN[NATIVE_DATA_WIDTH-1:TAP_W];

    assign CNTVALUEIN      = r_shadow;
    assign LOAD            = r_load;
    assign EN_VTC          = r_en_vtc;
    assign NATIVE_READY    = r_ready;
    assign NATIVE_DATA_OUT = r_data_out;

    vtc_load_seq #(
        .VTC_WAIT(VTC_WAIT)
    ) u_seq (
        .i_clk          (NATIVE_CLK),
        .i_rst          (NATIVE_RST),
        .i_start        (w_seq_start),
        .o_state        (w_seq_state),
        .o_enter_load   (w_enter_load),
        .o_enter_vtc_on (w_enter_vtc_on),
        .o_done         (w_seq_done)
    );

    // Load target: raw tap for TAP writes, clamped shadow+delta for STEP.
    always_comb begin
        w_sum    = {2'b00, r_shadow[r_idx]} + {{2{r_delta[TAP_W-1]}}, r_delta};
        w_target = r_delta;
        w_clamp  = 1'b0;
        if (r_reg == REG_STEP) begin
            if (w_sum[TAP_W+1]) begin
                w_target = '0;
                w_clamp  = 1'b1;
            end else if (w_sum[TAP_W]) begin
                w_target = TAP_MAX;
                w_clamp  = 1'b1;
            end else begin
                w_target = w_sum[TAP_W-1:0];
            end
        end else begin
            w_target = r_delta;
        end
    end

    // Read mux; out-of-range channels read as zero.
    always_comb begin
        w_rd_data = '0;
        if (r_valid) begin
            case (r_reg)
                REG_TAP:    w_rd_data = NATIVE_DATA_WIDTH'(w_cvo[r_idx]);
                REG_CTRL:   w_rd_data = NATIVE_DATA_WIDTH'(r_ctrl[r_idx]);
                REG_STATUS: w_rd_data = NATIVE_DATA_WIDTH'({r_sat[r_idx], w_busy});
                default:    w_rd_data = '0;
            endcase
        end else begin
            w_rd_data = '0;
        end
    end

    // Bus FSM plus per-channel shadow, control and strobe registers.
    always_ff @(posedge NATIVE_CLK or posedge NATIVE_RST) begin
        if (NATIVE_RST) begin
            r_state    <= CS_IDLE;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_reg      <= 2'b00;
            r_delta    <= '0;
            r_shadow   <= '0;
            r_ctrl     <= '1;
            r_sat      <= '0;
            r_load     <= '0;
            r_en_vtc   <= '1;
            r_ready    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_load     <= '0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
            case (r_state)
                CS_IDLE: begin
                    if (NATIVE_EN) begin
                        r_idx   <= w_idx_in;
                        r_valid <= w_valid_in;
                        r_reg   <= w_reg_in;
                        r_delta <= NATIVE_DATA_IN[TAP_W-1:0];
                        if (!NATIVE_WR) begin
                            r_state <= CS_RD;
                        end else if (w_is_load_in) begin
                            r_state            <= CS_SEQ;
                            r_en_vtc[w_idx_in] <= 1'b0;
                        end else begin
                            // Register-only writes (and stray channels) finish at once.
                            r_state <= CS_DONE;
                            r_ready <= 1'b1;
                            if (w_valid_in && (w_reg_in == REG_CTRL)) begin
                                r_ctrl[w_idx_in]   <= NATIVE_DATA_IN[0];
                                r_en_vtc[w_idx_in] <= NATIVE_DATA_IN[0];
                            end else if (w_valid_in && (w_reg_in == REG_STATUS) && NATIVE_DATA_IN[1]) begin
                                r_sat[w_idx_in] <= 1'b0;
                            end
                        end
                    end
                end
                CS_RD: begin
                    r_state    <= CS_DONE;
                    r_ready    <= 1'b1;
                    r_data_out <= w_rd_data;
                end
                CS_SEQ: begin
                    if (w_enter_load) begin
                        r_load[r_idx]   <= 1'b1;
                        r_shadow[r_idx] <= w_target;
                        if (w_clamp) r_sat[r_idx] <= 1'b1;
                    end
                    if (w_enter_vtc_on) r_en_vtc[r_idx] <= r_ctrl[r_idx];
                    if (w_seq_done) begin
                        r_state <= CS_DONE;
                        r_ready <= 1'b1;
                    end
                end
                CS_DONE: r_state <= CS_IDLE;
                default: r_state <= CS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_delay_core.sv
// Directed + random bench for multi_delay_core against a register-level model.
module tb_multi_delay_core;

    localparam int NUM_CH   = 4;
    localparam int TAP_W    = 9;
    localparam int DW       = 32;
    localparam int VTC_WAIT = 10;
    localparam int AW       = 4;
    localparam int TAP_MAXV = (1 << TAP_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    wr;
    logic [AW-1:0]           addr;
    logic [DW-1:0]           din;
    logic [DW-1:0]           dout;
    logic                    ready;
    logic [NUM_CH*TAP_W-1:0] cvi;
    logic [NUM_CH*TAP_W-1:0] cvo;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0]       en_vtc;

    int n_assert = 0;
    int n_fail   = 0;

    int m_shadow[NUM_CH];
    bit m_ctrl[NUM_CH];
    bit m_sat[NUM_CH];
    int cvo_m[NUM_CH];

    multi_delay_core #(
        .NUM_CH(NUM_CH), .TAP_W(TAP_W), .NATIVE_DATA_WIDTH(DW), .VTC_WAIT(VTC_WAIT)
    ) dut (
        .NATIVE_CLK(clk), .NATIVE_RST(rst), .NATIVE_EN(en), .NATIVE_WR(wr),
        .NATIVE_ADDR(addr), .NATIVE_DATA_IN(din), .NATIVE_DATA_OUT(dout),
        .NATIVE_READY(ready), .CNTVALUEIN(cvi), .LOAD(load), .EN_VTC(en_vtc),
        .CNTVALUEOUT(cvo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tap_of(input logic [NUM_CH*TAP_W-1:0] v, input int k);
        return int'(v[k*TAP_W +: TAP_W]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = 0;
            m_ctrl[k]   = 1'b1;
            m_sat[k]    = 1'b0;
        end
    endtask

    // Latency counts edges from the accepting edge to the edge that samples READY high;
    // sample j is taken on the falling edge after rising edge j.
    task automatic access(input logic w, input int ch, input int rg, input logic [DW-1:0] d,
                          input int inject_at,
                          output int lat, output int n_ready, output logic [DW-1:0] rdata,
                          output int load_at, output int n_load, output logic [NUM_CH-1:0] load_val,
                          output int cvi_load, output int en_pre, output int en_post,
                          output int side_bad);
        lat = -1; n_ready = 0; rdata = '0; load_at = -1; n_load = 0; load_val = '0;
        cvi_load = -1; en_pre = 0; en_post = 0; side_bad = 0;
        @(negedge clk);
        en = 1'b1; wr = w; addr = {2'(ch), 2'(rg)}; din = d;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (j == 0) en = 1'b0;
            if (j == inject_at) begin
                en = 1'b1; wr = 1'b1; addr = {2'((ch + 1) % NUM_CH), 2'd1}; din = 32'h0;
            end else if (j == inject_at + 1) begin
                en = 1'b0;
            end
            if (ready) begin
                n_ready++;
                if (lat < 0) begin
                    lat   = j + 1;
                    rdata = dout;
                end
            end else if (dout !== '0) begin
                side_bad++;
            end
            if (load !== '0) begin
                n_load++;
                if (load_at < 0) begin
                    load_at  = j;
                    load_val = load;
                    cvi_load = tap_of(cvi, ch);
                end
            end else if (en_vtc[ch] === 1'b0) begin
                if (load_at < 0) en_pre++;
                else en_post++;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (k != ch) begin
                    if (en_vtc[k] !== m_ctrl[k] || load[k] !== 1'b0 || tap_of(cvi, k) != m_shadow[k])
                        side_bad++;
                end
            end
            if (lat >= 0 && j >= lat + 1) break;
        end
        en = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic w, input int ch, input int rg,
                          input logic [DW-1:0] d, input int inject_at);
        int exp_lat, tgt, delta, lat, n_ready, load_at, n_load, cvi_load, en_pre, en_post, side_bad;
        bit is_load, clamp;
        logic [DW-1:0] exp_rd, rdata;
        logic [NUM_CH-1:0] load_val;
        is_load = w && (rg == 0 || rg == 2);
        exp_lat = !w ? 2 : (is_load ? 2 * VTC_WAIT + 3 : 1);
        case (rg)
            0:       exp_rd = 32'(cvo_m[ch]);
            1:       exp_rd = 32'(m_ctrl[ch]);
            3:       exp_rd = 32'(m_sat[ch]) << 1;
            default: exp_rd = 32'h0;
        endcase
        clamp = 1'b0;
        tgt   = int'(d[TAP_W-1:0]);
        if (rg == 2) begin
            delta = int'(d[TAP_W-1:0]);
            if (delta >= (1 << (TAP_W - 1))) delta = delta - (1 << TAP_W);
            tgt = m_shadow[ch] + delta;
            if (tgt < 0) begin
                tgt = 0; clamp = 1'b1;
            end else if (tgt > TAP_MAXV) begin
                tgt = TAP_MAXV; clamp = 1'b1;
            end
        end
        access(w, ch, rg, d, inject_at, lat, n_ready, rdata, load_at, n_load, load_val,
               cvi_load, en_pre, en_post, side_bad);
        check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s.ready_pulses", tag), 32'(n_ready), 32'd1);
        check($sformatf("%s.side_effects", tag), 32'(side_bad), 32'd0);
        if (!w && rg != 2) check($sformatf("%s.rdata", tag), rdata, exp_rd);
        if (is_load) begin
            check($sformatf("%s.load_cycle", tag), 32'(load_at), 32'(VTC_WAIT));
            check($sformatf("%s.load_count", tag), 32'(n_load), 32'd1);
            check($sformatf("%s.load_mask", tag), 32'(load_val), 32'(1 << ch));
            check($sformatf("%s.load_value", tag), 32'(cvi_load), 32'(tgt));
            if (m_ctrl[ch]) begin
                check($sformatf("%s.vtc_off_pre", tag), 32'(en_pre), 32'(VTC_WAIT));
                check($sformatf("%s.vtc_off_post", tag), 32'(en_post), 32'(VTC_WAIT));
            end
            m_shadow[ch] = tgt;
            if (clamp) m_sat[ch] = 1'b1;
        end else begin
            check($sformatf("%s.load_count", tag), 32'(n_load), 32'd0);
        end
        if (w && rg == 1) m_ctrl[ch] = d[0];
        if (w && rg == 3 && d[1]) m_sat[ch] = 1'b0;
        check($sformatf("%s.shadow", tag), 32'(tap_of(cvi, ch)), 32'(m_shadow[ch]));
        check($sformatf("%s.en_vtc", tag), 32'(en_vtc[ch]), 32'(m_ctrl[ch]));
    endtask

    initial begin
        int seen_ready, seen_load, r_ch, r_rg;
        logic r_w;
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        cvo_m[0] = 32'h0F0; cvo_m[1] = 32'h1A3; cvo_m[2] = 32'h00C; cvo_m[3] = 32'h13B;
        for (int k = 0; k < NUM_CH; k++) cvo[k*TAP_W +: TAP_W] = TAP_W'(cvo_m[k]);
        model_reset();

        repeat (3) @(negedge clk);
        check("reset.ready", 32'(ready), 32'd0);
        check("reset.load", 32'(load), 32'd0);
        check("reset.en_vtc", 32'(en_vtc), 32'hF);
        check("reset.cntvaluein", 32'(cvi), 32'd0);
        check("reset.dout", dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("rd_ch1", 1'b0, 1, 0, 32'h0, -1);
        run_op("tap_ch2", 1'b1, 2, 0, 32'hABCD_E055, -1);
        check("tap_ch2.const", 32'(tap_of(cvi, 2)), 32'h055);

        run_op("tap_ch3", 1'b1, 3, 0, 32'h1F0, -1);
        run_op("step_ch3_sat", 1'b1, 3, 2, 32'h020, -1);
        check("step_ch3_sat.const", 32'(tap_of(cvi, 3)), 32'h1FF);
        run_op("stat_ch3", 1'b0, 3, 3, 32'h0, -1);
        run_op("w1c_ch3", 1'b1, 3, 3, 32'h2, -1);
        run_op("stat_ch3_clr", 1'b0, 3, 3, 32'h0, -1);
        run_op("step_ch0_neg", 1'b1, 0, 2, 32'h1FD, -1);
        check("step_ch0_neg.const", 32'(tap_of(cvi, 0)), 32'h000);
        run_op("stat_ch0", 1'b0, 0, 3, 32'h0, -1);
        run_op("step_ch2", 1'b1, 2, 2, 32'h010, -1);

        run_op("busy_ch1", 1'b1, 1, 0, 32'h0AA, VTC_WAIT + 5);
        run_op("busy_ctrl_rd", 1'b0, 2, 1, 32'h0, -1);

        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = {2'd2, 2'd0}; din = 32'h123;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.vtc_off", 32'(en_vtc[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid.en_vtc", 32'(en_vtc), 32'hF);
        check("rst_mid.load", 32'(load), 32'd0);
        check("rst_mid.ready", 32'(ready), 32'd0);
        check("rst_mid.cntvaluein", 32'(cvi), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_ready = 0; seen_load = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (ready) seen_ready++;
            if (load !== '0) seen_load++;
        end
        check("rst_mid.no_ready", 32'(seen_ready), 32'd0);
        check("rst_mid.no_load", 32'(seen_load), 32'd0);
        check("rst_mid.en_after", 32'(en_vtc), 32'hF);
        run_op("rst_mid.read", 1'b0, 1, 0, 32'h0, -1);

        run_op("ctrl0_off", 1'b1, 0, 1, 32'h0, -1);
        check("ctrl0_off.en0", 32'(en_vtc[0]), 32'd0);
        run_op("tap_ch0_vtcoff", 1'b1, 0, 0, 32'h011, -1);
        check("tap_ch0_vtcoff.en0", 32'(en_vtc[0]), 32'd0);

        for (int i = 0; i < 24; i++) begin
            r_ch = int'($urandom_range(NUM_CH - 1, 0));
            r_rg = int'($urandom_range(3, 0));
            r_w  = 1'($urandom_range(1, 0));
            if (!r_w && r_rg == 2) r_rg = 0;
            run_op($sformatf("rnd%0d", i), r_w, r_ch, r_rg, $urandom, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
